// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand widths, opcode encodings and execute-stage FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a. The register bank decode uses the same opcode constants.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int MUL_CNT_W = 3;  // log2(DATA_W) iteration counter

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_MOV = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/exec_writeback_if.sv
// Bundle between register bank (master) and execute/write-back stage (slave).
// Latency: n/a (wires only).
// Backpressure: o_stall tells the bank to hold i_* steady while a multiply runs.
// Ports: i_opcode/i_destadd/i_read_data1/i_read_data2 toward the stage;
//        o_write_en/o_write_reg/o_write_data, o_flag_z/o_flag_c, o_stall back to the bank.
interface exec_writeback_if;
  import cpu_pkg::*;

  logic [3:0]        i_opcode;
  logic [ADDR_W-1:0] i_destadd;
  logic [DATA_W-1:0] i_read_data1;
  logic [DATA_W-1:0] i_read_data2;
  logic              o_write_en;
  logic [ADDR_W-1:0] o_write_reg;
  logic [DATA_W-1:0] o_write_data;
  logic              o_flag_z;
  logic              o_flag_c;
  logic              o_stall;

  modport master (
    output i_opcode, i_destadd, i_read_data1, i_read_data2,
    input  o_write_en, o_write_reg, o_write_data, o_flag_z, o_flag_c, o_stall
  );

  modport slave (
    input  i_opcode, i_destadd, i_read_data1, i_read_data2,
    output o_write_en, o_write_reg, o_write_data, o_flag_z, o_flag_c, o_stall
  );

endinterface

// File: rtl/shift_add_mul.sv
// Iterative 8x8 unsigned shift-add multiplier, one partial product per cycle.
// Latency: start edge loads operands; done is high combinationally during the 8th iteration cycle.
// Backpressure: start is ignored while busy; caller must wait for done.
// Ports: clk, reset_n (async active-low), start, a, b in; done, product (valid with done) out.
module shift_add_mul
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] partial;
  logic [DATA_W-1:0]   mplier;
  logic [MUL_CNT_W-1:0] cnt;
  logic                busy;

  // product is the accumulator after the current step, so the final
  // result is visible on the same cycle that done is high.
  assign partial = mplier[0] ? mcand : '0;
  assign product = acc + partial;
  assign done    = busy && (cnt == MUL_CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start && !busy) begin
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + MUL_CNT_W'(1);
      busy   <= !done;
    end
  end

endmodule

// File: rtl/exec_writeback.sv
// Execute + write-back stage: 8-bit ALU, Z/C flags, optional iterative MUL (macro EXEC_MUL_EN).
// Latency: single-cycle ops 1 cycle; MUL 9 cycles of occupancy, result registered on the 8th iteration edge.
// Backpressure: o_stall is high while MUL runs; inputs are not sampled then and must be held upstream.
// Ports: i_clk, i_reset (async active-low), bus (exec_writeback_if.slave).
module exec_writeback
  import cpu_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  exec_writeback_if.slave  bus
);

  logic              in_idle;
  logic              upd;
  logic [DATA_W-1:0] res;
  logic              carry;
  logic [ADDR_W-1:0] wb_reg;

  logic              write_en_q;
  logic [ADDR_W-1:0] write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic              flag_z_q;
  logic              flag_c_q;

`ifdef EXEC_MUL_EN
  state_t              state;
  state_t              state_nx;
  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;
  logic [ADDR_W-1:0]   mul_dest;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mul_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_opcode == OP_MUL) begin
          state_nx  = ST_MUL;
          mul_start = 1'b1;
        end
      end
      ST_MUL: begin
        if (mul_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // The multiplier holds its own operands; only the destination needs keeping here.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)       mul_dest <= '0;
    else if (mul_start) mul_dest <= bus.i_destadd;
  end

  shift_add_mul u_mul (
    .clk     (i_clk),
    .reset_n (i_reset),
    .start   (mul_start),
    .a       (bus.i_read_data1),
    .b       (bus.i_read_data2),
    .done    (mul_done),
    .product (mul_product)
  );

  assign in_idle     = (state == ST_IDLE);
  assign bus.o_stall = (state == ST_MUL);
`else
  assign in_idle     = 1'b1;
  assign bus.o_stall = 1'b0;
`endif

  // Result selection: single-cycle ALU ops when idle, multiplier result on its last iteration.
  always_comb begin
    upd    = 1'b0;
    res    = '0;
    carry  = 1'b0;
    wb_reg = bus.i_destadd;
    if (in_idle) begin
      upd = 1'b1;
      case (bus.i_opcode)
        OP_ADD: {carry, res} = {1'b0, bus.i_read_data1} + {1'b0, bus.i_read_data2};
        // Bit 8 of the 9-bit difference is the unsigned borrow.
        OP_SUB: {carry, res} = {1'b0, bus.i_read_data1} - {1'b0, bus.i_read_data2};
        OP_AND: res = bus.i_read_data1 & bus.i_read_data2;
        OP_OR:  res = bus.i_read_data1 | bus.i_read_data2;
        OP_XOR: res = bus.i_read_data1 ^ bus.i_read_data2;
        OP_NOT: res = ~bus.i_read_data1;
        OP_SHL: begin
          res   = bus.i_read_data1 << 1;
          carry = bus.i_read_data1[DATA_W-1];
        end
        OP_SHR: begin
          res   = bus.i_read_data1 >> 1;
          carry = bus.i_read_data1[0];
        end
        OP_MOV: res = bus.i_read_data1;
        // NOP, MUL start (result comes later) and unused encodings.
        default: upd = 1'b0;
      endcase
    end
`ifdef EXEC_MUL_EN
    else if (mul_done) begin
      upd    = 1'b1;
      res    = mul_product[DATA_W-1:0];
      carry  = |mul_product[2*DATA_W-1:DATA_W];
      wb_reg = mul_dest;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      write_en_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      flag_z_q     <= 1'b0;
      flag_c_q     <= 1'b0;
    end else begin
      // Register 0 is never written, but its op still updates the flags.
      write_en_q <= upd && (wb_reg != '0);
      if (upd) begin
        flag_z_q <= (res == '0);
        flag_c_q <= carry;
      end
      if (upd && (wb_reg != '0)) begin
        write_reg_q  <= wb_reg;
        write_data_q <= res;
      end
    end
  end

  assign bus.o_write_en   = write_en_q;
  assign bus.o_write_reg  = write_reg_q;
  assign bus.o_write_data = write_data_q;
  assign bus.o_flag_z     = flag_z_q;
  assign bus.o_flag_c     = flag_c_q;

endmodule
